// File: rtl/ysyx_22040632_ifu_q.sv
// ysyx_22040632_ifu_q: decoupled instruction fetch with credit-limited pipelined requests,
// a DEPTH-entry (pc, inst, err) FIFO, and redirect-driven flushing of stale responses.
module ysyx_22040632_ifu_q #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [ILEN-1:0]            imem_rsp_data,
    input  logic                       imem_rsp_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ILEN-1:0]            out_inst,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [ILEN-1:0] inst_mem [DEPTH];
    logic            err_mem  [DEPTH];
    logic [CW:0]     credit;
    logic            accept, push, pop, dropping;

    // Every outstanding request owns a FIFO slot, so responses can never be refused.
    assign credit         = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req_valid = !rst && !redirect_valid && credit < (CW+1)'(DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign dropping       = drop_q != '0;
    assign push           = imem_rsp_valid && !dropping && !redirect_valid;
    assign out_valid      = count_q != '0;
    assign pop            = out_valid && out_ready;
    assign occupancy      = count_q;
    assign out_pc         = out_valid ? pc_mem[rptr_q] : '0;
    assign out_inst       = out_valid ? inst_mem[rptr_q] : '0;
    assign out_err        = out_valid && err_mem[rptr_q];

    always_comb begin
        fetch_pc_d = redirect_valid ? redirect_pc : accept ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        rsp_pc_d   = redirect_valid ? redirect_pc : push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
        inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
        // On redirect every request still in flight (minus one answering now) becomes stale.
        drop_d     = redirect_valid ? inflight_q - CW'(imem_rsp_valid)
                   : (imem_rsp_valid && dropping) ? drop_q - CW'(1) : drop_q;
        count_d    = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        wptr_d     = redirect_valid ? '0 : wptr_q + AW'(push);
        rptr_d     = redirect_valid ? '0 : rptr_q + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr_q]   <= rsp_pc_q;
            inst_mem[wptr_q] <= imem_rsp_data;
            err_mem[wptr_q]  <= imem_rsp_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && count_q == CW'(DEPTH)));
    end
endmodule

// File: tb/tb_ysyx_22040632_ifu_q.sv
// tb_ysyx_22040632_ifu_q: directed scenarios against a queue-based model of requests in flight
// and buffered instructions, plus literal pins on addresses, occupancy and handed-off pcs.
module tb_ysyx_22040632_ifu_q;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 0, rst = 1, redirect_valid = 0, imem_req_ready = 0;
    logic        imem_rsp_valid = 0, imem_rsp_err = 0, out_ready = 0;
    logic [63:0] redirect_pc = '0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_req_valid, out_valid, out_err;
    logic [63:0] imem_req_addr, out_pc;
    logic [31:0] out_inst;
    logic [2:0]  occupancy;

    ysyx_22040632_ifu_q #(.XLEN(64), .ILEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_err(out_err), .occupancy(occupancy));

    always #5 clk = ~clk;

    typedef struct {logic [63:0] addr; int due; bit stale;} req_t;
    typedef struct {logic [63:0] pc; logic [31:0] inst; logic err;} ent_t;
    req_t        pend[$];
    ent_t        outs[$];
    logic [63:0] lit[$];
    logic        lit_e[$];
    logic [63:0] fetch_pc = RST_PC;
    logic [63:0] err_addr = '1;
    int          cyc = 0, lat = 1, handoffs = 0, total = 0, bad = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] + 32'h1000_0013;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h cyc=%0d", n, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit r, input bit rd, input logic [63:0] rpc, input bit ordy, input bit qrdy);
        bit rv, ev;
        ent_t h;
        rst = r; redirect_valid = rd; redirect_pc = rpc; out_ready = ordy; imem_req_ready = qrdy;
        rv = !r && pend.size() > 0 && pend[0].due <= cyc;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? inst_of(pend[0].addr) : '0;
        imem_rsp_err   = rv && pend[0].addr == err_addr;
        #1;
        ev = !r && !rd && (pend.size() + outs.size() < DEPTH);
        h = outs.size() > 0 ? outs[0] : '{64'h0, 32'h0, 1'b0};
        chk("req_valid", 64'(imem_req_valid), 64'(ev));
        if (ev) chk("req_addr", imem_req_addr, fetch_pc);
        chk("out_valid", 64'(out_valid), 64'(outs.size() > 0));
        chk("occupancy", 64'(occupancy), 64'(outs.size()));
        chk("out_pc", out_pc, h.pc);
        chk("out_inst", 64'(out_inst), 64'(h.inst));
        chk("out_err", 64'(out_err), 64'(h.err));
        if (!r && !rd && out_valid && ordy) begin
            handoffs++;
            if (lit.size() > 0) chk("lit_pc", out_pc, lit.pop_front());
            if (lit_e.size() > 0) chk("lit_err", 64'(out_err), 64'(lit_e.pop_front()));
        end
        if (r) begin
            pend.delete(); outs.delete(); fetch_pc = RST_PC;
        end else if (rd) begin
            if (rv) void'(pend.pop_front());
            foreach (pend[i]) pend[i].stale = 1;
            outs.delete(); fetch_pc = rpc;
        end else begin
            if (outs.size() > 0 && ordy) void'(outs.pop_front());
            if (rv) begin
                req_t q = pend.pop_front();
                if (!q.stale) outs.push_back('{q.addr, inst_of(q.addr), q.addr == err_addr});
            end
            if (ev && qrdy) begin
                pend.push_back('{fetch_pc, cyc + lat, 1'b0});
                fetch_pc += 64'd4;
            end
        end
        @(posedge clk); @(negedge clk); cyc++;
    endtask

    task automatic run(input int n, input bit ordy, input bit qrdy);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, ordy, qrdy);
    endtask

    initial begin
        int h0;
        @(negedge clk); @(posedge clk); @(negedge clk);
        cycle(1, 0, '0, 0, 1);
        cycle(1, 0, '0, 0, 1);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        // streaming, 1-cycle memory
        lat = 1; cyc = 0;
        rst = 0; #1;
        chk("first_addr", imem_req_addr, 64'h8000_0000);
        lit = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C};
        h0 = handoffs;
        run(12, 1, 1);
        chk("throughput", 64'(handoffs - h0), 64'd10);
        chk("lit_left1", 64'(lit.size()), 64'd0);
        // back-pressure fills the FIFO
        cycle(1, 0, '0, 0, 1);
        run(10, 0, 1);
        chk("full_occ", 64'(occupancy), 64'd4);
        chk("full_req", 64'(imem_req_valid), 64'd0);
        lit = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C, 64'h8000_0010};
        cycle(0, 0, '0, 1, 1);
        chk("resume_valid", 64'(imem_req_valid), 64'd1);
        chk("resume_addr", imem_req_addr, 64'h8000_0010);
        run(8, 1, 1);
        chk("lit_left2", 64'(lit.size()), 64'd0);
        // redirect with three requests in flight
        cycle(1, 0, '0, 1, 1);
        lat = 4; cyc = 0;
        run(3, 1, 1);
        cycle(0, 1, 64'h8000_0100, 1, 1);
        chk("redir_occ", 64'(occupancy), 64'd0);
        lit = '{64'h8000_0100, 64'h8000_0104, 64'h8000_0108};
        run(14, 1, 1);
        chk("lit_left3", 64'(lit.size()), 64'd0);
        // redirect colliding with a response and an out handshake
        cycle(1, 0, '0, 1, 1);
        lat = 2; cyc = 0;
        run(3, 1, 1);
        chk("pre_redir_valid", 64'(out_valid), 64'd1);
        cycle(0, 1, 64'h8000_0200, 1, 1);
        chk("redir2_occ", 64'(occupancy), 64'd0);
        run(1, 1, 1);
        chk("drop_one_occ", 64'(occupancy), 64'd0);
        lit = '{64'h8000_0200, 64'h8000_0204};
        run(8, 1, 1);
        chk("lit_left4", 64'(lit.size()), 64'd0);
        // access fault on the second fetch
        cycle(1, 0, '0, 1, 1);
        lat = 1; cyc = 0; err_addr = 64'h8000_0004;
        lit = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C};
        lit_e = '{1'b0, 1'b1, 1'b0, 1'b0};
        run(8, 1, 1);
        chk("lit_left5", 64'(lit.size() + lit_e.size()), 64'd0);
        // memory stall, then reset mid-stream
        run(5, 1, 0);
        run(2, 1, 1);
        cycle(1, 0, '0, 1, 1);
        chk("mid_rst_req", 64'(imem_req_valid), 64'd0);
        chk("mid_rst_outv", 64'(out_valid), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        cyc = 0;
        lit = '{64'h8000_0000, 64'h8000_0004};
        run(6, 1, 1);
        chk("lit_left6", 64'(lit.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
